// File: rtl/hazard_tracker_pkg.sv
// Shared pipeline header for the hazard tracker: forwarding-select codes,
// Tuse/Tnew helpers, instruction-type codes and the per-stage tracking types.
package hazard_tracker_pkg;

  typedef logic [4:0] regIdx_t;
  typedef logic [1:0] tval_t;

  // Source-select encodings shared by the D-stage and E-stage forwarding muxes.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,  // regfile (D) or the E-register value (E)
    FWD_E   = 2'b01,
    FWD_M   = 2'b10,
    FWD_W   = 2'b11
  } fwdSel_e;

  // Decoder Tuse value meaning "this source field is not read".
  localparam tval_t TUSE_NONE = 2'b11;

  // An operand sitting in E is consumed right now, so any producer that is
  // still not ready in M is a pending (late) hazard for it.
  localparam tval_t TUSE_E_STAGE = 2'b00;

  // Instruction classes produced by the decoder that feeds this block.
  typedef enum logic [2:0] {
    INSTR_NOP       = 3'd0,
    INSTR_ALU_R     = 3'd1,
    INSTR_ALU_I     = 3'd2,
    INSTR_LOAD      = 3'd3,
    INSTR_STORE     = 3'd4,
    INSTR_BRANCH    = 3'd5,
    INSTR_JUMP_LINK = 3'd6,
    INSTR_JUMP_REG  = 3'd7
  } instrType_e;

  typedef struct packed {
    regIdx_t rs;
    regIdx_t rt;
    regIdx_t dst;
    tval_t   eTnew;
    tval_t   mTnew;
  } eStage_t;

  typedef struct packed {
    regIdx_t dst;
    tval_t   tnew;
  } mStage_t;

  typedef struct packed {
    regIdx_t dst;
  } wStage_t;

  typedef struct packed {
    eStage_t e;
    mStage_t m;
    wStage_t w;
  } trackState_t;

  // Debug view: full tracking state plus E-stage operands whose producer in M
  // is still not ready.
  typedef struct packed {
    trackState_t state;
    logic        eRsPending;
    logic        eRtPending;
  } dbg_t;

  // A bubble carries no sources, no destination and no latency.
  localparam eStage_t E_BUBBLE = '0;

  // Register 0 is hardwired: it never creates a dependency.
  function automatic logic srcLive(input regIdx_t r);
    return r != '0;
  endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// Decoder-facing bundle of the hazard tracker: D-stage instruction fields in,
// stall / forwarding selects / tracked destinations out.
interface hazard_tracker_if;
  import hazard_tracker_pkg::*;

  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_TuseRs;
  logic [1:0] D_TuseRt;
  logic [4:0] D_dst;
  logic [1:0] D_ETnew;
  logic [1:0] D_MTnew;

  logic       stall;
  logic [1:0] D_fwdRs;
  logic [1:0] D_fwdRt;
  logic [1:0] E_fwdRs;
  logic [1:0] E_fwdRt;
  logic [4:0] E_dst;
  logic [4:0] M_dst;
  logic [4:0] W_dst;
  dbg_t       dbg;

  // Pipeline contract: the D fields are sampled on every rising edge. While
  // stall is high the upstream stages hold the D instruction and this block
  // places a bubble into E; all outputs are combinational in the same cycle.
  modport master (
    output D_rs, D_rt, D_TuseRs, D_TuseRt, D_dst, D_ETnew, D_MTnew,
    input  stall, D_fwdRs, D_fwdRt, E_fwdRs, E_fwdRt, E_dst, M_dst, W_dst, dbg
  );

  modport slave (
    input  D_rs, D_rt, D_TuseRs, D_TuseRt, D_dst, D_ETnew, D_MTnew,
    output stall, D_fwdRs, D_fwdRt, E_fwdRs, E_fwdRt, E_dst, M_dst, W_dst, dbg
  );

endinterface

// File: rtl/hazard_match.sv
// Evaluates one source operand against up to three younger-to-older producer
// stages: raises a stall when a matching producer is later than the operand's
// use time, and picks the nearest ready matching producer for forwarding.
module hazard_match
  import hazard_tracker_pkg::*;
(
  input  regIdx_t    src,
  input  tval_t      tuse,
  input  logic       nearEn,
  input  regIdx_t    nearDst,
  input  tval_t      nearTnew,
  input  regIdx_t    midDst,
  input  tval_t      midTnew,
  input  regIdx_t    farDst,
  output logic       stall,
  output logic [1:0] fwdSel
);

  logic live;
  logic reads;
  logic nearHit;
  logic midHit;
  logic farHit;

  // Match, stall and priority-select for a single source operand.
  always_comb begin
    live    = srcLive(src);
    reads   = (tuse != TUSE_NONE);
    nearHit = live & nearEn & (nearDst == src);
    midHit  = live & (midDst == src);
    farHit  = live & (farDst == src);

    stall = reads & ((nearHit & (nearTnew > tuse)) | (midHit & (midTnew > tuse)));

    // A matching producer that is not ready yet is skipped so an older ready
    // copy can still be forwarded; the stall logic covers the real hazard.
    fwdSel = FWD_REG;
    if (nearHit && (nearTnew == '0)) begin
      fwdSel = FWD_E;
    end else if (midHit && (midTnew == '0)) begin
      fwdSel = FWD_M;
    end else if (farHit) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Tracks destination/latency information for the E, M and W stages of a
// five-stage pipeline and produces the D-stage stall plus the D- and E-stage
// forwarding selects from it.
module hazard_tracker
  import hazard_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  hazard_tracker_if.slave  hz
);

  trackState_t cur;
  eStage_t     dIn;
  logic        stallRs;
  logic        stallRt;
  logic        stallNow;
  logic        eRsPending;
  logic        eRtPending;
  logic [1:0]  dFwdRs;
  logic [1:0]  dFwdRt;
  logic [1:0]  eFwdRs;
  logic [1:0]  eFwdRt;

  // Collect the D-stage fields into the record that enters E.
  always_comb begin
    dIn       = E_BUBBLE;
    dIn.rs    = hz.D_rs;
    dIn.rt    = hz.D_rt;
    dIn.dst   = hz.D_dst;
    dIn.eTnew = hz.D_ETnew;
    dIn.mTnew = hz.D_MTnew;
  end

  hazard_match u_dRs (
    .src      (hz.D_rs),
    .tuse     (hz.D_TuseRs),
    .nearEn   (1'b1),
    .nearDst  (cur.e.dst),
    .nearTnew (cur.e.eTnew),
    .midDst   (cur.m.dst),
    .midTnew  (cur.m.tnew),
    .farDst   (cur.w.dst),
    .stall    (stallRs),
    .fwdSel   (dFwdRs)
  );

  hazard_match u_dRt (
    .src      (hz.D_rt),
    .tuse     (hz.D_TuseRt),
    .nearEn   (1'b1),
    .nearDst  (cur.e.dst),
    .nearTnew (cur.e.eTnew),
    .midDst   (cur.m.dst),
    .midTnew  (cur.m.tnew),
    .farDst   (cur.w.dst),
    .stall    (stallRt),
    .fwdSel   (dFwdRt)
  );

  // E-stage operands only see M and W; the near slot is disabled.
  hazard_match u_eRs (
    .src      (cur.e.rs),
    .tuse     (TUSE_E_STAGE),
    .nearEn   (1'b0),
    .nearDst  ('0),
    .nearTnew ('0),
    .midDst   (cur.m.dst),
    .midTnew  (cur.m.tnew),
    .farDst   (cur.w.dst),
    .stall    (eRsPending),
    .fwdSel   (eFwdRs)
  );

  hazard_match u_eRt (
    .src      (cur.e.rt),
    .tuse     (TUSE_E_STAGE),
    .nearEn   (1'b0),
    .nearDst  ('0),
    .nearTnew ('0),
    .midDst   (cur.m.dst),
    .midTnew  (cur.m.tnew),
    .farDst   (cur.w.dst),
    .stall    (eRtPending),
    .fwdSel   (eFwdRt)
  );

  assign stallNow = stallRs | stallRt;

  // Advance the tracking pipeline; a stall injects a bubble into E while M
  // and W keep draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= '0;
    end else begin
      cur.e      <= stallNow ? E_BUBBLE : dIn;
      cur.m.dst  <= cur.e.dst;
      cur.m.tnew <= cur.e.mTnew;
      cur.w.dst  <= cur.m.dst;
    end
  end

  // Drive the bundle outputs straight from the current state and matches.
  always_comb begin
    hz.stall          = stallNow;
    hz.D_fwdRs        = dFwdRs;
    hz.D_fwdRt        = dFwdRt;
    hz.E_fwdRs        = eFwdRs;
    hz.E_fwdRt        = eFwdRt;
    hz.E_dst          = cur.e.dst;
    hz.M_dst          = cur.m.dst;
    hz.W_dst          = cur.w.dst;
    hz.dbg.state      = cur;
    hz.dbg.eRsPending = eRsPending;
    hz.dbg.eRtPending = eRtPending;
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed table of instruction pairs, a reset
// during a load-use stall, then randomized traffic against a stage-list model.
module tb_hazard_tracker;

  logic clk = 1'b0;
  logic reset = 1'b1;

  hazard_tracker_if hz();

  hazard_tracker dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tr;
    logic [1:0] tt;
    logic [4:0] dst;
    logic [1:0] eT;
    logic [1:0] mT;
    logic       stall;
    logic [1:0] dRs;
    logic [1:0] dRt;
    logic [1:0] eRs;
    logic [1:0] eRt;
    logic [4:0] eD;
    logic [4:0] mD;
    logic [4:0] wD;
  } vec_t;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] eT;
    logic [1:0] mT;
  } instr_t;

  vec_t   tbl[19];
  instr_t pipe[3];  // index 0 = E, 1 = M, 2 = W

  // ---------------- driver tasks ----------------
  task automatic driveD(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] tr, input logic [1:0] tt,
                        input logic [4:0] dst, input logic [1:0] eT,
                        input logic [1:0] mT);
    hz.D_rs     = rs;
    hz.D_rt     = rt;
    hz.D_TuseRs = tr;
    hz.D_TuseRt = tt;
    hz.D_dst    = dst;
    hz.D_ETnew  = eT;
    hz.D_MTnew  = mT;
  endtask

  task automatic driveIdle();
    driveD(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic checkField(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  function automatic logic [23:0] packOut(input logic st, input logic [1:0] dRs,
                                          input logic [1:0] dRt, input logic [1:0] eRs,
                                          input logic [1:0] eRt, input logic [4:0] eD,
                                          input logic [4:0] mD, input logic [4:0] wD);
    return {st, dRs, dRt, eRs, eRt, eD, mD, wD};
  endfunction

  task automatic checkAll(input string nm, input logic [23:0] exp);
    logic [23:0] act;
    act = packOut(hz.stall, hz.D_fwdRs, hz.D_fwdRt, hz.E_fwdRs, hz.E_fwdRt,
                  hz.E_dst, hz.M_dst, hz.W_dst);
    checkField(nm, "stall",   int'(act[23]),    int'(exp[23]));
    checkField(nm, "D_fwdRs", int'(act[22:21]), int'(exp[22:21]));
    checkField(nm, "D_fwdRt", int'(act[20:19]), int'(exp[20:19]));
    checkField(nm, "E_fwdRs", int'(act[18:17]), int'(exp[18:17]));
    checkField(nm, "E_fwdRt", int'(act[16:15]), int'(exp[16:15]));
    checkField(nm, "E_dst",   int'(act[14:10]), int'(exp[14:10]));
    checkField(nm, "M_dst",   int'(act[9:5]),   int'(exp[9:5]));
    checkField(nm, "W_dst",   int'(act[4:0]),   int'(exp[4:0]));
  endtask

  // ---------------- reference model ----------------
  // Pipeline as a list of in-flight instructions; an instruction's Tnew is
  // its E-time value while in E, its M-time value while in M, 0 in W.
  function automatic int tnewAt(input int s);
    if (s == 0) return int'(pipe[0].eT);
    if (s == 1) return int'(pipe[1].mT);
    return 0;
  endfunction

  function automatic logic mdlStall(input logic [4:0] src, input logic [1:0] tuse);
    if (src == 0 || tuse == 2'd3) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (pipe[s].dst == src && tnewAt(s) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  // Nearest stage holding a ready copy of src, searched from firstStage on.
  function automatic logic [1:0] mdlFwd(input logic [4:0] src, input int firstStage);
    if (src == 0) return 2'd0;
    for (int s = firstStage; s < 3; s++)
      if (pipe[s].dst == src && tnewAt(s) == 0) return 2'(s + 1);
    return 2'd0;
  endfunction

  function automatic logic [23:0] mdlExpect(input instr_t d, input logic [1:0] tr,
                                            input logic [1:0] tt);
    logic st;
    st = mdlStall(d.rs, tr) | mdlStall(d.rt, tt);
    return packOut(st, mdlFwd(d.rs, 0), mdlFwd(d.rt, 0),
                   mdlFwd(pipe[0].rs, 1), mdlFwd(pipe[0].rt, 1),
                   pipe[0].dst, pipe[1].dst, pipe[2].dst);
  endfunction

  function automatic instr_t bubble();
    instr_t b;
    b.rs = '0; b.rt = '0; b.dst = '0; b.eT = '0; b.mT = '0;
    return b;
  endfunction

  // ---------------- test ----------------
  initial begin
    instr_t     d;
    logic [1:0] tr;
    logic [1:0] tt;
    logic [23:0] e;
    logic       rst;

    //          rs  rt tr tt dst eT mT | st dRs dRt eRs eRt eD mD wD
    tbl[0]  = '{0,  0, 3, 3, 0,  0, 0,   0, 0, 0, 0, 0, 0,  0,  0};  // idle
    tbl[1]  = '{4,  0, 1, 3, 1,  2, 1,   0, 0, 0, 0, 0, 0,  0,  0};  // lw $1
    tbl[2]  = '{1,  3, 1, 1, 2,  1, 0,   1, 0, 0, 0, 0, 1,  0,  0};  // add uses $1: stall
    tbl[3]  = '{1,  3, 1, 1, 2,  1, 0,   0, 0, 0, 0, 0, 0,  1,  0};  // stall released
    tbl[4]  = '{2,  0, 1, 3, 5,  1, 0,   0, 0, 0, 3, 0, 2,  0,  1};  // add in E gets W
    tbl[5]  = '{5,  0, 0, 0, 0,  0, 0,   1, 0, 0, 2, 0, 5,  2,  0};  // beq after ori
    tbl[6]  = '{5,  0, 0, 0, 0,  0, 0,   0, 2, 0, 0, 0, 0,  5,  2};  // beq takes M
    tbl[7]  = '{0,  0, 3, 3, 31, 0, 0,   0, 0, 0, 3, 0, 0,  0,  5};  // jal
    tbl[8]  = '{31, 0, 0, 3, 0,  0, 0,   0, 1, 0, 0, 0, 31, 0,  0};  // jr $31 takes E
    tbl[9]  = '{2,  3, 1, 1, 1,  1, 0,   0, 0, 0, 2, 0, 0,  31, 0};  // add $1
    tbl[10] = '{4,  1, 1, 2, 0,  0, 0,   0, 0, 0, 0, 0, 1,  0,  31}; // sw $1: no stall
    tbl[11] = '{0,  0, 3, 3, 0,  0, 0,   0, 0, 0, 0, 2, 0,  1,  0};  // sw in E gets M
    tbl[12] = '{0,  0, 3, 3, 0,  2, 1,   0, 0, 0, 0, 0, 0,  0,  1};  // writer of $0
    tbl[13] = '{0,  0, 0, 0, 3,  1, 0,   0, 0, 0, 0, 0, 0,  0,  0};  // reader of $0
    tbl[14] = '{0,  0, 3, 3, 0,  0, 0,   0, 0, 0, 0, 0, 3,  0,  0};
    tbl[15] = '{0,  0, 3, 3, 6,  3, 2,   0, 0, 0, 0, 0, 0,  3,  0};  // Tnew=3 producer
    tbl[16] = '{6,  6, 2, 3, 0,  0, 0,   1, 0, 0, 0, 0, 6,  0,  3};  // 3>2 stalls
    tbl[17] = '{6,  6, 2, 3, 0,  0, 0,   0, 0, 0, 0, 0, 0,  6,  0};  // 2>2 does not
    tbl[18] = '{0,  0, 3, 3, 0,  0, 0,   0, 0, 0, 3, 3, 0,  0,  6};  // both from W

    // reset state
    reset = 1'b1;
    driveIdle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAll("reset", 24'h0);

    // directed table
    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      driveD(tbl[i].rs, tbl[i].rt, tbl[i].tr, tbl[i].tt, tbl[i].dst, tbl[i].eT, tbl[i].mT);
      @(negedge clk);
      checkAll($sformatf("vec%0d", i),
               packOut(tbl[i].stall, tbl[i].dRs, tbl[i].dRt, tbl[i].eRs, tbl[i].eRt,
                       tbl[i].eD, tbl[i].mD, tbl[i].wD));
    end

    // reset asserted during a load-use stall
    @(posedge clk);
    #1;
    reset = 1'b1;
    driveIdle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    driveD(5'd4, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 2'd1);  // lw $1
    @(posedge clk);
    #1;
    driveD(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd1, 2'd0);  // add $2,$1,$3
    @(negedge clk);
    checkAll("rst_pre", packOut(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd1, 5'd0, 5'd0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkAll("rst_mid_stall", 24'h0);

    // randomized traffic against the model
    @(posedge clk);
    #1;
    reset = 1'b1;
    driveIdle();
    for (int s = 0; s < 3; s++) pipe[s] = bubble();
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      rst   = ($urandom_range(0, 31) == 0);
      reset = rst;
      d.rs  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      d.rt  = 5'($urandom_range(0, 3));
      d.dst = 5'($urandom_range(0, 3));
      d.eT  = 2'($urandom_range(0, 3));
      d.mT  = 2'($urandom_range(0, 3));
      tr    = 2'($urandom_range(0, 3));
      tt    = 2'($urandom_range(0, 3));
      driveD(d.rs, d.rt, tr, tt, d.dst, d.eT, d.mT);
      @(negedge clk);
      exp_q.push_back(mdlExpect(d, tr, tt));
      e = exp_q.pop_front();
      checkAll($sformatf("rnd%0d", n), e);
      // state after the coming edge
      if (rst) begin
        for (int s = 0; s < 3; s++) pipe[s] = bubble();
      end else begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e[23] ? bubble() : d;
      end
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-003 D_rs  input  5  rs field of instruction in D.
REQ-004 D_rt  input  5  rt field of instruction in D.
REQ-005 D_TuseRs  input  2  decoder Tuse for rs; 2'b11 = rs not read.
REQ-006 D_TuseRt  input  2  decoder Tuse for rt; 2'b11 = rt not read.
REQ-007 D_dst  input  5  resolved destination register of D instruction; 0 = no write.
REQ-008 D_ETnew  input  2  decoder Tnew valid while the instruction sits in E.
REQ-009 D_MTnew  input  2  decoder Tnew valid while the instruction sits in M.
REQ-010 stall  output  1  freeze PC and F/D; insert bubble into E.
REQ-011 D_fwdRs, D_fwdRt  output  2 each  D-stage source select: 00 regfile, 01 E, 10 M, 11 W.
REQ-012 E_fwdRs, E_fwdRt  output  2 each  E-stage source select: 00 E-register value, 10 M, 11 W.
REQ-013 E_dst, M_dst, W_dst  output  5 each  tracked destination per stage, for the forwarding muxes.

Function
REQ-014 Tracking state: E {rs, rt, dst, ETnew, MTnew}; M {dst, Tnew}; W {dst}; all registered.
REQ-015 Each cycle without stall: E <= D inputs; M.dst <= E.dst, M.Tnew <= E.MTnew; W.dst <= M.dst.
REQ-016 Cycle with stall: E <= bubble (all fields 0); M and W advance as in REQ-015.
REQ-017 Stall is combinational, same cycle: stallRs | stallRt.
REQ-018 stallRs = (D_rs != 0) & (D_TuseRs != 3) & ((E.dst == D_rs & E.ETnew > D_TuseRs) | (M.dst == D_rs & M.Tnew > D_TuseRs)); stallRt is analogous with rt.
REQ-019 Tnew/Tuse comparisons are unsigned 2-bit.
REQ-020 D_fwdRs priority: E (E.dst == D_rs, E.ETnew == 0) > M (M.dst == D_rs, M.Tnew == 0) > W (W.dst == D_rs) > 00. Forced 00 when D_rs == 0. D_fwdRt is analogous.
REQ-021 E_fwdRs priority: M (M.dst == E.rs, M.Tnew == 0) > W (W.dst == E.rs) > 00. Forced 00 when E.rs == 0. E_fwdRt is analogous.
REQ-022 Register 0 never causes a stall or a forward, even when a stage dst is 0 and a source field is 0.
REQ-023 A stage with dst != 0 but Tnew > 0 does not forward; it stalls per REQ-018 or yields to a lower-priority ready source.
REQ-024 Forward select is valid in the same cycle as its inputs; the stage registers add no latency.

Reset
REQ-025 On reset all tracking fields are 0 and every stage is a bubble; outputs derive from that state (stall=0, all fwd=00, all dst=0).
REQ-026 Reset asserted mid-stall clears all state on that edge; stall deasserts the following cycle unless D inputs re-create a hazard.

Structure
REQ-027 The forwarding-select encodings, the Tuse "not read" value (2'b11) and the bubble constant belong in the shared pipeline header, alongside the instruction-type codes.
REQ-028 One sub-module, hazard_match, evaluates a single source: (src, Tuse, stage dst/Tnew) -> stall bit and forward select. It is instantiated once each for D.rs, D.rt, E.rs and E.rt.

Verification
REQ-029 lw $1 then add $2,$1,$3 back-to-back (E: dst=1, ETnew=2; D: TuseRs=1) -> stall=1 for exactly 1 cycle, bubble in E, then E_fwdRs=11 (W) after lw reaches W.
REQ-030 ori $1 then beq $1,$0 (E.ETnew=1, TuseRs=0) -> stall 1 cycle; next cycle D_fwdRs=10 (M).
REQ-031 jal (dst=31, ETnew=0) then jr $31 -> no stall; D_fwdRs=01.
REQ-032 add $1 then sw $1,0($4) (TuseRt=2) -> no stall; one cycle later E_fwdRt=10 (M).
REQ-033 Instruction writing $0 followed by a reader of $0 -> stall=0, all fwd=00.
REQ-034 Reset asserted during a lw-use stall -> next cycle E_dst=M_dst=W_dst=0 and stall=0.
